// File: rtl/input_pkg.sv
// input_pkg: channel state encoding and default timing shared by the debounce block.
package input_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} ch_state_e;
  localparam int DEF_NBTN = 4;
  localparam int DEF_DB_SAMPLES = 3;
  localparam int DEF_REPEAT_DELAY = 20;
  localparam int DEF_REPEAT_RATE = 5;
  localparam logic [3:0] DEF_REPEAT_MASK = 4'b0111;
endpackage

// File: rtl/db_channel.sv
// db_channel: one button -- synchronizer, tick-sampled debounce and press/auto-repeat FSM.
module db_channel
  import input_pkg::*;
#(
  parameter int DB_SAMPLES   = DEF_DB_SAMPLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic btn_n_i,
  output logic held_o,
  output logic pulse_o
);
  logic [1:0] sync_q;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic       held_q, held_d, db_done;
  ch_state_e  state_q, state_d;
  logic [7:0] rcnt_q, rcnt_d;
  logic [8:0] rcnt_inc;
  logic       pulse_raw, pulse_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      state_q <= IDLE;
      rcnt_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], ~btn_n_i};
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      pulse_q <= pulse_o;
    end
  // Debounce: a run of disagreeing tick samples flips the level; any agreeing sample restarts it.
  always_comb begin
    cnt_inc = cnt_q + 4'd1;
    db_done = tick_i && (sync_q[1] != held_q) && (cnt_inc == 4'(DB_SAMPLES));
    cnt_d   = !tick_i ? cnt_q : ((sync_q[1] == held_q) || db_done) ? 4'd0 : cnt_inc;
    held_d  = held_q ^ db_done;
  end
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    pulse_raw = 1'b0;
    rcnt_inc  = {1'b0, rcnt_q} + 9'd1;
    if (!held_q) begin
      state_d = IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = DELAY;
          rcnt_d    = '0;
          pulse_raw = 1'b1;
        end
        DELAY:
          if (tick_i) begin
            if (!REPEAT_EN) rcnt_d = (rcnt_q == 8'hff) ? rcnt_q : rcnt_inc[7:0];
            else if (rcnt_inc == 9'(REPEAT_DELAY)) begin
              state_d   = REPEAT;
              rcnt_d    = '0;
              pulse_raw = 1'b1;
            end else rcnt_d = rcnt_inc[7:0];
          end
        REPEAT:
          if (tick_i) begin
            pulse_raw = (rcnt_inc == 9'(REPEAT_RATE));
            rcnt_d    = pulse_raw ? 8'd0 : rcnt_inc[7:0];
          end
        default: state_d = IDLE;
      endcase
    end
  end
  assign pulse_o = pulse_raw & ~pulse_q;
  assign held_o  = held_q;
endmodule

// File: rtl/input_debounce.sv
// input_debounce: NBTN independent debounced push-button channels with press and auto-repeat strobes.
module input_debounce
  import input_pkg::*;
#(
  parameter int              NBTN         = DEF_NBTN,
  parameter int              DB_SAMPLES   = DEF_DB_SAMPLES,
  parameter int              REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int              REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter logic [NBTN-1:0] REPEAT_MASK  = NBTN'(DEF_REPEAT_MASK)
) (
  input  logic            CLOCK_50,
  input  logic            resetn,
  input  logic            tick_input,
  input  logic [NBTN-1:0] btn_n,
  output logic [NBTN-1:0] held,
  output logic [NBTN-1:0] press_pulse
);
  for (genvar i = 0; i < NBTN; i++) begin : g_ch
    db_channel #(
      .DB_SAMPLES  (DB_SAMPLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .REPEAT_EN   (REPEAT_MASK[i])
    ) u_ch (
      .clk    (CLOCK_50),
      .rst_n  (resetn),
      .tick_i (tick_input),
      .btn_n_i(btn_n[i]),
      .held_o (held[i]),
      .pulse_o(press_pulse[i])
    );
  end
endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: directed press, bounce, auto-repeat, mask, simultaneity and reset-abort checks.
module tb_input_debounce;
  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       tick_input = 1'b0;
  logic [3:0] btn_n = 4'hf;
  logic [3:0] held, press_pulse;
  int total = 0, bad = 0, ticks = 0;
  int pc[4];
  int stamp[$];
  int pulse_cycles = 0, viol = 0;
  logic [3:0] first_pat = '0, prev_pp = '0;
  logic held1_seen = 1'b0;
  int exp_rep[7] = '{3, 23, 28, 33, 38, 43, 48};
  always #10 CLOCK_50 = ~CLOCK_50;
  input_debounce dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .tick_input (tick_input),
    .btn_n      (btn_n),
    .held       (held),
    .press_pulse(press_pulse)
  );
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic clr_log();
    for (int c = 0; c < 4; c++) pc[c] = 0;
    stamp.delete();
    pulse_cycles = 0;
    first_pat = '0;
    held1_seen = 1'b0;
  endtask
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (4) @(posedge CLOCK_50);
      #1 tick_input = 1'b1;
      ticks++;
      @(posedge CLOCK_50);
      #1 tick_input = 1'b0;
    end
  endtask
  always @(negedge CLOCK_50) begin
    if (|(press_pulse & prev_pp)) viol++;
    prev_pp = press_pulse;
    if (held[1]) held1_seen = 1'b1;
    if (|press_pulse) begin
      pulse_cycles++;
      if (first_pat == 4'd0) first_pat = press_pulse;
      if (press_pulse[2]) stamp.push_back(ticks);
      for (int c = 0; c < 4; c++) if (press_pulse[c]) pc[c]++;
    end
  end
  initial begin
    for (int c = 0; c < 4; c++) pc[c] = 0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("rst_held", int'(held), 0);
    chk("rst_pulse", int'(press_pulse), 0);
    @(posedge CLOCK_50);
    #1 resetn = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    chk("idle_held", int'(held), 0);
    clr_log();
    btn_n[0] = 1'b0;
    tick(2);
    chk("b0_held_t2", int'(held[0]), 0);
    tick(1);
    chk("b0_held_t3", int'(held[0]), 1);
    tick(2);
    chk("b0_one_pulse", pc[0], 1);
    btn_n[0] = 1'b1;
    tick(3);
    chk("b0_release", int'(held[0]), 0);
    chk("b0_no_rel_pulse", pc[0], 1);
    clr_log();
    btn_n[1] = 1'b0;
    tick(2);
    btn_n[1] = 1'b1;
    tick(1);
    btn_n[1] = 1'b0;
    tick(2);
    btn_n[1] = 1'b1;
    tick(4);
    chk("b1_bounce_held", int'(held1_seen), 0);
    chk("b1_bounce_pulse", pc[1], 0);
    clr_log();
    ticks = 0;
    btn_n[2] = 1'b0;
    tick(50);
    chk("b2_rep_count", pc[2], 7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("b2_rep_tick%0d", i), (i < stamp.size()) ? stamp[i] : -1, exp_rep[i]);
    btn_n[2] = 1'b1;
    tick(3);
    chk("b2_release", int'(held[2]), 0);
    clr_log();
    btn_n[3] = 1'b0;
    tick(50);
    chk("b3_mask_pulse", pc[3], 1);
    btn_n[3] = 1'b1;
    tick(3);
    repeat (2) @(posedge CLOCK_50);
    chk("b3_release", int'(held[3]), 0);
    chk("b3_no_rel_pulse", pc[3], 1);
    clr_log();
    btn_n = 4'b1010;
    tick(3);
    repeat (2) @(posedge CLOCK_50);
    chk("sim_pattern", int'(first_pat), 5);
    chk("sim_cycles", pulse_cycles, 1);
    btn_n = 4'hf;
    tick(3);
    chk("sim_release", int'(held), 0);
    clr_log();
    ticks = 0;
    btn_n[2] = 1'b0;
    tick(30);
    chk("rr_pre_pulses", pc[2], 3);
    @(posedge CLOCK_50);
    #1 resetn = 1'b0;
    @(negedge CLOCK_50);
    chk("rr_held_in_rst", int'(held), 0);
    chk("rr_pulse_in_rst", int'(press_pulse), 0);
    repeat (2) @(posedge CLOCK_50);
    #1 resetn = 1'b1;
    clr_log();
    ticks = 0;
    tick(2);
    chk("rr_held_t2", int'(held[2]), 0);
    chk("rr_no_rel_pulse", pc[2], 0);
    tick(1);
    chk("rr_held_t3", int'(held[2]), 1);
    tick(20);
    chk("rr_pulses", pc[2], 2);
    chk("rr_first_tick", (stamp.size() > 0) ? stamp[0] : -1, 3);
    chk("rr_repeat_tick", (stamp.size() > 1) ? stamp[1] : -1, 23);
    btn_n[2] = 1'b1;
    tick(3);
    chk("no_back_to_back", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
